// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue
//
// Instruction-fetch front end feeding the IF/ID register. It owns the fetch
// PC, issues one request at a time to a variable-latency instruction memory,
// and buffers returned words (tagged with PC+4) in a DEPTH-entry FIFO that
// decode drains with a valid/ready handshake. A redirect flushes the FIFO
// and retargets fetch. A request already on the bus at that moment cannot be
// withdrawn, so it is completed with its original address and its data is
// thrown away.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (overrides every other input)
//   redirect     taken branch/jump; flushes the queue
//   redirect_pc  new fetch address when redirect=1
//   imem_req     instruction-memory request
//   imem_addr    byte address of the request
//   imem_ack     response valid (may arrive in the same cycle as imem_req)
//   imem_rdata   instruction word when imem_ack=1
//   d_ready      decode accepts the head entry
//   d_valid      queue non-empty
//   d_inst       head instruction (0 when empty)
//   d_pc         head PC+4 (0 when empty)
//   count        current queue occupancy
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int         CNT_W    = $clog2(DEPTH + 1),
  localparam int         PTR_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             d_ready,
  output logic             d_valid,
  output logic [31:0]      d_inst,
  output logic [31:0]      d_pc,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t             state;
  logic [31:0]        fetch_pc;
  logic [31:0]        kill_addr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;

  // Queue storage is datapath only: it is never reset because every read is
  // qualified by count, which is.
  logic [31:0]        inst_mem [DEPTH];
  logic [31:0]        pc_mem   [DEPTH];

  logic               ack_taken;
  logic               push;
  logic               pop;

  // Request/address decode. In IDLE the registered count gates the request;
  // a pop in the same cycle deliberately does not open room early, which
  // keeps imem_req free of any path from d_ready.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fetch_pc;
    case (state)
      ST_IDLE:    imem_req = (count < CNT_W'(DEPTH));
      ST_WAIT:    imem_req = 1'b1;
      ST_DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = kill_addr;
      end
      default:    imem_req = 1'b0;
    endcase
    if (rst) begin
      imem_req = 1'b0;
    end
  end

  // A response is only meaningful while our request is up. Responses to a
  // killed request (DISCARD) or arriving with a redirect are dropped.
  assign ack_taken = imem_req && imem_ack;
  assign push      = ack_taken && !redirect && (state != ST_DISCARD);
  assign d_valid   = (count != '0);
  assign pop       = d_valid && d_ready && !redirect;

  // Empty queue presents the pipeline-flush values.
  assign d_inst = d_valid ? inst_mem[rd_ptr] : 32'h0;
  assign d_pc   = d_valid ? pc_mem[rd_ptr]   : 32'h0;

  // Control: FSM, fetch PC, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      // An acked transaction always finishes, even alongside a redirect;
      // only a still-pending request is converted into a discard.
      case (state)
        ST_IDLE: begin
          if (imem_req && !imem_ack) begin
            if (redirect) begin
              state     <= ST_DISCARD;
              kill_addr <= fetch_pc;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (imem_ack) begin
            state <= ST_IDLE;
          end else if (redirect) begin
            state     <= ST_DISCARD;
            kill_addr <= fetch_pc;
          end
        end
        ST_DISCARD: begin
          if (imem_ack) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (redirect) begin
        fetch_pc <= redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + PTR_W'(1);
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (pop && !push) begin
          count <= count - CNT_W'(1);
        end
      end
    end
  end

  // Datapath: queue write. fetch_pc is still the address of this word, so
  // fetch_pc+4 is the link/next-PC value carried with it.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= fetch_pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
module tb_fetch_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        d_ready = 1'b0;
  logic        d_valid;
  logic [31:0] d_inst;
  logic [31:0] d_pc;
  logic [2:0]  count;

  always #5 clk = ~clk;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .d_ready(d_ready), .d_valid(d_valid),
    .d_inst(d_inst), .d_pc(d_pc), .count(count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a transaction-level view of the front end.
  logic [31:0] mq_inst[$];
  logic [31:0] mq_pc[$];
  logic [31:0] m_fpc    = RESET_PC;
  bit          m_outst  = 0;  // a request is on the bus, not yet acked
  bit          m_killed = 0;  // that request's data must be thrown away
  logic [31:0] m_kaddr  = '0;
  bit          started  = 0;

  // Memory environment
  bit mem_busy = 0;
  int mem_lat  = 0;

  // Stimulus knobs (percentages)
  int lat_max      = 0;
  int pct_redirect = 0;
  int pct_ready    = 100;
  int pct_rst      = 0;

  task automatic step();
    bit          e_req;
    bit          ack_eff;
    logic [31:0] e_addr;
    @(negedge clk);
    rst         = ($urandom_range(99) < pct_rst);
    redirect    = ($urandom_range(99) < pct_redirect);
    redirect_pc = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
    d_ready     = ($urandom_range(99) < pct_ready);

    e_req  = !rst && (m_outst || (mq_inst.size() < DEPTH));
    e_addr = m_killed ? m_kaddr : m_fpc;

    if (e_req && !mem_busy) begin
      mem_busy = 1;
      mem_lat  = $urandom_range(lat_max);
    end
    imem_ack   = e_req && mem_busy && (mem_lat == 0);
    imem_rdata = imem_ack ? (32'h1000 + e_addr) : $urandom;

    #1;
    if (started) begin
      check_eq("imem_req", {31'b0, imem_req}, {31'b0, e_req});
      if (e_req) check_eq("imem_addr", imem_addr, e_addr);
      check_eq("count", {29'b0, count}, 32'(mq_inst.size()));
      check_eq("d_valid", {31'b0, d_valid}, {31'b0, (mq_inst.size() != 0)});
      check_eq("d_inst", d_inst, (mq_inst.size() != 0) ? mq_inst[0] : 32'h0);
      check_eq("d_pc", d_pc, (mq_pc.size() != 0) ? mq_pc[0] : 32'h0);
    end

    ack_eff = e_req && imem_ack;
    if (rst) begin
      mq_inst.delete();
      mq_pc.delete();
      m_fpc    = RESET_PC;
      m_outst  = 0;
      m_killed = 0;
      mem_busy = 0;
      started  = 1;
    end else begin
      if (redirect) begin
        mq_inst.delete();
        mq_pc.delete();
        if (ack_eff) begin
          m_outst  = 0;
          m_killed = 0;
        end else if (e_req) begin
          if (!m_killed) m_kaddr = m_fpc;
          m_killed = 1;
          m_outst  = 1;
        end
        m_fpc = redirect_pc;
      end else begin
        if (mq_inst.size() != 0 && d_ready) begin
          void'(mq_inst.pop_front());
          void'(mq_pc.pop_front());
        end
        if (ack_eff && !m_killed) begin
          mq_inst.push_back(imem_rdata);
          mq_pc.push_back(m_fpc + 32'd4);
          m_fpc = m_fpc + 32'd4;
        end
        if (ack_eff) begin
          m_outst  = 0;
          m_killed = 0;
        end else if (e_req) begin
          m_outst = 1;
        end
      end
      if (mem_busy) begin
        if (imem_ack) mem_busy = 0;
        else mem_lat--;
      end
    end
  endtask

  initial begin
    // Reset, then combinational ack with decode always ready.
    pct_rst = 100;
    repeat (2) step();
    pct_rst = 0;
    lat_max = 0; pct_redirect = 0; pct_ready = 100;
    repeat (12) step();

    // Decode stalled: queue fills, request drops; then a single pop.
    pct_ready = 0;
    repeat (8) step();
    pct_ready = 100;
    step();
    pct_ready = 0;
    repeat (3) step();

    // Slow memory, steady drain.
    lat_max = 3; pct_ready = 100;
    repeat (60) step();

    // Random latency, stalls and redirects.
    pct_ready = 70; pct_redirect = 10;
    repeat (800) step();

    // Heavy redirects with combinational ack.
    lat_max = 0; pct_redirect = 40; pct_ready = 50;
    repeat (300) step();

    // Everything, including occasional reset.
    lat_max = 3; pct_redirect = 10; pct_ready = 60; pct_rst = 3;
    repeat (1500) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register and the decode stage.
- Owns the fetch PC and issues one-at-a-time requests to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned instructions, with their PC+4, in a small FIFO and presents them to decode with valid/ready.
- Branch and jump redirects flush the queue and discard any in-flight fetch.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- RESET_PC, 32'h00000000, fetch PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect  in  1  taken branch or jump from a later stage; flushes the queue.
- redirect_pc  in  32  new fetch address, valid when redirect=1.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  byte address of the request.
- imem_ack  in  1  response valid; may be asserted in the same cycle as imem_req.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- d_ready  in  1  decode accepts the head entry; low during a hazard stall.
- d_valid  out  1  queue is non-empty.
- d_inst  out  32  instruction at the queue head.
- d_pc  out  32  PC+4 of the head instruction.
- count  out  $clog2(DEPTH+1)  current queue occupancy.

Behaviour:
- Reset (rst=1 at an edge):
  - fetch_pc=RESET_PC, queue empty, count=0, state=IDLE.
  - d_valid=0, d_inst=0, d_pc=0.
  - imem_req=0 while rst is high.
  - The instruction memory shares rst, so any outstanding transaction is cancelled by reset. Reset overrides every other input.
- State machine: IDLE, WAIT (request outstanding), DISCARD (outstanding request killed by a redirect).
- imem_req:
  - IDLE: imem_req = (count<DEPTH). The registered count is used; a same-cycle pop does not add room.
  - WAIT and DISCARD: imem_req=1 unconditionally.
- imem_addr:
  - IDLE and WAIT: imem_addr=fetch_pc.
  - DISCARD: imem_addr=kill_addr.
- Handshake rule: once imem_req rises, imem_req and imem_addr stay stable until the cycle with imem_ack=1, including across redirects.
- Transitions:
  - IDLE, imem_req&&!imem_ack&&!redirect -> WAIT.
  - IDLE, imem_req&&!imem_ack&&redirect -> DISCARD; kill_addr<=fetch_pc.
  - WAIT, imem_ack -> IDLE.
  - WAIT, !imem_ack&&redirect -> DISCARD; kill_addr<=fetch_pc.
  - DISCARD, imem_ack -> IDLE; response dropped.
  - All other cases: hold state.
- Push:
  - Condition: imem_ack in IDLE (with imem_req) or in WAIT, with redirect=0.
  - Writes {imem_rdata, fetch_pc+4} at the tail; fetch_pc<=fetch_pc+4.
  - With a combinational ack this sustains 1 fetch/cycle.
- Pop: d_valid&&d_ready advances the head. A simultaneous push and pop leaves count unchanged.
- Overflow: structurally impossible, because a request is only issued when count<DEPTH and pops only free space.
- Redirect (highest priority after rst):
  - Queue cleared and count=0 at the next edge.
  - A pop in the same cycle is ignored; an ack in the same cycle is not pushed.
  - fetch_pc<=redirect_pc, in every state.
  - A redirect while in DISCARD updates fetch_pc and stays in DISCARD.
- Output when empty: d_inst=0 (nop) and d_pc=0, matching pipeline-register flush values.
- Output when non-empty: d_inst and d_pc come from the head entry, driven directly from the registered queue storage.
- Arithmetic: fetch_pc+4 and pointer increments wrap modulo 2^32 and modulo DEPTH respectively.
- Latency: first request in the first cycle after rst falls; with a same-cycle ack, d_valid=1 one cycle later.

Test Plan:
- Combinational ack (ack=req), memory holds word = 0x1000+addr, d_ready=1 -> imem_addr sequence 0,4,8,..., one per cycle; first d_valid one cycle after rst falls with d_inst=0x1000, d_pc=4.
- Same memory, d_ready=0 -> four pushes, count=4, imem_req=0; then one cycle of d_ready=1 -> count=3 and imem_req=1 in the following cycle with imem_addr=0x10.
- Ack after 3 cycles -> imem_req and imem_addr stay stable for 3 cycles, state WAIT; steady throughput of one entry per 4 cycles, d_pc increasing by 4.
- Redirect to 0x40 in the 2nd cycle of WAIT for addr 0x8:
  - Next cycle: queue empty, state DISCARD, imem_addr still 0x8.
  - The ack for 0x8 is dropped; the next request is addr 0x40.
  - First post-redirect entry has d_pc=0x44.
- Redirect, combinational ack, and d_ready=1 all in one cycle with count=2 -> next cycle count=0, d_valid=0, d_inst=0, imem_addr=redirect_pc; acked word never appears.
- rst pulsed high for one cycle during WAIT with count=3 -> next cycle all outputs zero, state IDLE; after rst falls, the first request is at RESET_PC.
